// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the 1x4 dispatch controller.
// The channel scan lives here so the rr_pick_4 sub-module and later arbiters share one definition.
package demux_dispatch_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } state_t;

  typedef logic [1:0] ch_idx_t;

  typedef struct packed {
    logic    found;
    ch_idx_t idx;
  } pick_t;

  // First set bit of mask at or above ptr, wrapping 3 -> 0.
  function automatic pick_t next_enabled(ch_idx_t ptr, logic [NUM_CH-1:0] mask);
    pick_t   res;
    ch_idx_t cand;
    res = '0;
    // Walk offsets from far to near so the nearest enabled channel is written last and wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + ch_idx_t'(i);
      if (mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_dispatch_1x4_rr_pick_4.sv
// Combinational enabled-channel scan from a starting pointer.
module rr_pick_4
  import demux_dispatch_pkg::*;
(
  input  logic [1:0] i_ptr,
  input  logic [3:0] i_mask,
  output logic [1:0] o_idx,
  output logic       o_found
);

  pick_t w_pick;

  always_comb begin
    w_pick  = next_enabled(i_ptr, i_mask);
    o_idx   = w_pick.idx;
    o_found = w_pick.found;
  end

endmodule

// File: rtl/demux_dispatch_1x4.sv
// 1x4 valid/ready dispatcher: one holding register, addressed or round-robin routing,
// beats for disabled channels in addressed mode are dropped and counted.
module demux_dispatch_1x4
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rr_mode,
  input  logic [3:0]           i_ch_en,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DW-1:0]        i_in_data,
  input  logic [1:0]           i_in_dest,
  output logic [3:0]           o_out_valid,
  input  logic [3:0]           i_out_ready,
  output logic [4*DW-1:0]      o_out_data,
  output logic [1:0]           o_rr_ptr,
  output logic [DROP_W-1:0]    o_drop_cnt
);

  state_t              r_state;
  state_t              w_state_nxt;
  ch_idx_t             r_dest;
  ch_idx_t             w_dest_nxt;
  logic [DW-1:0]       r_data;
  logic [DW-1:0]       w_data_nxt;
  ch_idx_t             r_rr_ptr;
  ch_idx_t             w_rr_ptr_nxt;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic [DROP_W-1:0]   w_drop_cnt_nxt;

  logic [1:0]          w_pick_idx;
  logic                w_pick_found;
  logic                w_hs;
  logic                w_dest_ok;
  logic                w_accept;
  ch_idx_t             w_chosen;
  logic                w_chosen_en;

  rr_pick_4 u_rr_pick (
    .i_ptr   (r_rr_ptr),
    .i_mask  (i_ch_en),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    w_hs        = (r_state == HOLD) && i_out_ready[r_dest];
    w_dest_ok   = i_rr_mode ? w_pick_found : 1'b1;
    o_in_ready  = ((r_state == IDLE) || w_hs) && w_dest_ok;
    w_accept    = i_in_valid && o_in_ready;
    w_chosen    = i_rr_mode ? w_pick_idx : i_in_dest;
    w_chosen_en = i_ch_en[w_chosen];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dest_nxt     = r_dest;
    w_data_nxt     = r_data;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_drop_cnt_nxt = r_drop_cnt;

    if (w_hs) begin
      w_state_nxt = IDLE;
      w_data_nxt  = '0;
    end

    if (w_accept) begin
      if (w_chosen_en) begin
        w_state_nxt = HOLD;
        w_dest_nxt  = w_chosen;
        w_data_nxt  = i_in_data;
      end else if (r_drop_cnt != {DROP_W{1'b1}}) begin
        w_drop_cnt_nxt = r_drop_cnt + DROP_W'(1);
      end
      // Only round-robin picks advance the pointer; they are always to an enabled channel.
      if (i_rr_mode) begin
        w_rr_ptr_nxt = w_chosen + ch_idx_t'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_dest     <= '0;
      r_data     <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dest     <= w_dest_nxt;
      r_data     <= w_data_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  always_comb begin
    o_out_valid = '0;
    o_out_data  = '0;
    if (r_state == HOLD) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_idx_t'(k) == r_dest) begin
          o_out_valid[k]          = 1'b1;
          o_out_data[k*DW +: DW]  = r_data;
        end
      end
    end
  end

  assign o_rr_ptr   = r_rr_ptr;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Self-checking bench for demux_dispatch_1x4: directed scenarios plus a randomized run
// compared against a transaction-level model of the dispatcher.
module tb_demux_dispatch_1x4;

  localparam int DW       = 8;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rr_mode = 1'b0;
  logic [3:0]      ch_en = 4'hF;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [1:0]      in_dest = '0;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = 4'hF;
  logic [4*DW-1:0] out_data;
  logic [1:0]      rr_ptr;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: the beat in flight, the round-robin pointer and the drop tally.
  bit            m_hold;
  int            m_dest;
  logic [DW-1:0] m_data;
  int            m_ptr;
  int            m_drop;

  always #5 clk = ~clk;

  demux_dispatch_1x4 #(
    .DW     (DW),
    .DROP_W (DROP_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rr_mode   (rr_mode),
    .i_ch_en     (ch_en),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_dest   (in_dest),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_rr_ptr    (rr_ptr),
    .o_drop_cnt  (drop_cnt)
  );

  function automatic int scan_rr();
    for (int off = 0; off < 4; off++) begin
      if (ch_en[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
    end
    return -1;
  endfunction

  function automatic logic exp_ready();
    logic ok;
    ok = rr_mode ? (ch_en != 4'b0000) : 1'b1;
    return (!m_hold || out_ready[m_dest]) && ok;
  endfunction

  function automatic logic [3:0] exp_valid();
    return m_hold ? (4'b0001 << m_dest) : 4'b0000;
  endfunction

  function automatic logic [4*DW-1:0] exp_data();
    logic [4*DW-1:0] v;
    v = '0;
    if (m_hold) v[m_dest*DW +: DW] = m_data;
    return v;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_dest = 0;
    m_data = '0;
    m_ptr  = 0;
    m_drop = 0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] dst,
                       input logic [3:0] ordy);
    in_valid  = v;
    in_data   = d;
    in_dest   = dst;
    out_ready = ordy;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit hs;
    bit acc;
    int ch;
    hs  = m_hold && out_ready[m_dest];
    acc = in_valid && exp_ready();
    ch  = rr_mode ? scan_rr() : int'(in_dest);
    @(posedge clk);
    if (hs) m_hold = 1'b0;
    if (acc) begin
      if (ch_en[ch]) begin
        m_hold = 1'b1;
        m_dest = ch;
        m_data = in_data;
      end else if (m_drop < DROP_MAX) begin
        m_drop++;
      end
      if (rr_mode) m_ptr = (ch + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rr_mode = 1'b0;
    ch_en   = 4'hF;
    drive(1'b1, 8'h5A, 2'd1, 4'b0000);
    tick();
    drive(1'b0, 8'h00, 2'd0, 4'b0000);
    #1;
    checks++;
    if (out_valid !== 4'b0010) begin
      errors++;
      $display("FAIL reset_pre_hold out_valid=%b want=0010", out_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_async_clear out_valid=%b out_data=%h want 0000/0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || rr_ptr !== 2'd0 || drop_cnt !== '0 || out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release in_ready=%b rr_ptr=%0d drop=%0d ov=%b want 1/0/0/0000",
               in_ready, rr_ptr, drop_cnt, out_valid);
    end
  endtask

  task automatic test_addressed();
    do_reset();
    rr_mode = 1'b0;
    ch_en   = 4'hF;
    drive(1'b1, 8'hA5, 2'd2, 4'hF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL addr_ready0 got=%b want=1", in_ready);
    end
    tick();
    drive(1'b1, 8'h3C, 2'd0, 4'hF);
    #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== 8'hA5 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL addr_first ov=%b lane2=%h rdy=%b want 0100/a5/1",
               out_valid, out_data[2*DW +: DW], in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 2'd0, 4'hF);
    #1;
    checks++;
    if (out_valid !== 4'b0001 || out_data !== 32'h0000_003C) begin
      errors++;
      $display("FAIL addr_second ov=%b data=%h want 0001/0000003c", out_valid, out_data);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      errors++;
      $display("FAIL addr_drain ov=%b data=%h want 0000/0", out_valid, out_data);
    end
  endtask

  task automatic test_drop();
    do_reset();
    rr_mode = 1'b0;
    ch_en   = 4'b1011;
    drive(1'b1, 8'h77, 2'd2, 4'hF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready got=%b want=1", in_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 4'b0000 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL drop_one ov=%b drop=%0d want 0000/1", out_valid, drop_cnt);
    end
    for (int i = 1; i < 260; i++) tick();
    drive(1'b0, 8'h00, 2'd0, 4'hF);
    #1;
    checks++;
    if (drop_cnt !== 8'd255 || drop_cnt !== m_drop[DROP_W-1:0]) begin
      errors++;
      $display("FAIL drop_saturate got=%0d want=255", drop_cnt);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_ch [6] = '{1, 3, 1, 3, 1, 3};
    do_reset();
    rr_mode = 1'b1;
    ch_en   = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(k + 1), 2'd0, 4'hF);
      tick();
      #1;
      checks++;
      if (out_valid !== (4'b0001 << exp_ch[k]) || out_data[exp_ch[k]*DW +: DW] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL rr_beat%0d ov=%b lane=%h want ch%0d data %0d", k, out_valid,
                 out_data[exp_ch[k]*DW +: DW], exp_ch[k], k + 1);
      end
    end
    drive(1'b0, 8'h00, 2'd0, 4'hF);
    #1;
    checks++;
    if (rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rr_ptr_wrap got=%0d want=0", rr_ptr);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rr_mode = 1'b0;
    ch_en   = 4'hF;
    drive(1'b1, 8'h9E, 2'd1, 4'hF);
    tick();
    drive(1'b1, 8'h11, 2'd3, 4'b1101);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data[DW +: DW] !== 8'h9E) begin
        errors++;
        $display("FAIL bp_stall%0d rdy=%b ov=%b lane1=%h want 0/0010/9e", i, in_ready,
                 out_valid, out_data[DW +: DW]);
      end
      tick();
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b1000 || out_data !== 32'h1100_0000) begin
      errors++;
      $display("FAIL bp_next ov=%b data=%h want 1000/11000000", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_all_disabled();
    do_reset();
    rr_mode = 1'b1;
    ch_en   = 4'b0000;
    drive(1'b1, 8'hC3, 2'd0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 4'b0000) begin
        errors++;
        $display("FAIL dis_stall%0d rdy=%b drop=%0d ov=%b want 0/0/0000", i, in_ready,
                 drop_cnt, out_valid);
      end
      tick();
    end
    ch_en = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dis_enable_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== 8'hC3 || rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL dis_route ov=%b lane2=%h ptr=%0d want 0100/c3/3", out_valid,
               out_data[2*DW +: DW], rr_ptr);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 7) == 0) ch_en = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
            4'($urandom | $urandom));
      #1;
      checks++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid() || out_data !== exp_data() ||
          rr_ptr !== 2'(m_ptr) || drop_cnt !== DROP_W'(m_drop)) begin
        errors++;
        $display("FAIL rand_c%0d rdy=%b/%b ov=%b/%b data=%h/%h ptr=%0d/%0d drop=%0d/%0d", c,
                 in_ready, exp_ready(), out_valid, exp_valid(), out_data, exp_data(),
                 rr_ptr, m_ptr, drop_cnt, m_drop);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_addressed();
    test_drop();
    test_rr_wrap();
    test_backpressure();
    test_all_disabled();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
